// File: rtl/pipelined_barrel_shifter_pkg.sv
// pipelined_barrel_shifter_pkg: mode encodings, stage control payload and mode decode helper
// Build option: PIPELINED_BARREL_SHIFTER_ROTATE_EN enables the ROL/ROR datapath.
package pipelined_barrel_shifter_pkg;

    typedef enum logic [2:0] {
        MODE_LSL  = 3'b000,
        MODE_LSR  = 3'b001,
        MODE_ASR  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_PASS = 3'b101
    } shift_mode_t;

    // Width-independent part of the per-stage payload; data and amt travel
    // alongside it with their parametrised widths.
    typedef struct packed {
        logic        valid;
        logic        carry;
        shift_mode_t mode;
    } stage_ctrl_t;

    // Canonicalise the raw mode field once at the input so stages only see
    // the modes they implement: 101-111 collapse to PASS, and without the
    // rotate datapath ROL/ROR degrade to LSL/LSR.
    function automatic shift_mode_t effective_mode(input logic [2:0] m);
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
        return (m > 3'd4) ? MODE_PASS : shift_mode_t'(m);
`else
        return (m == 3'd3) ? MODE_LSL :
               (m == 3'd4) ? MODE_LSR :
               (m > 3'd4)  ? MODE_PASS : shift_mode_t'(m);
`endif
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// barrel_shift_stage: combinational shift/rotate by 2^K when its amount bit is set
// Build option: PIPELINED_BARREL_SHIFTER_ROTATE_EN adds the ROL/ROR cases.
module barrel_shift_stage
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0
) (
    input  stage_ctrl_t      ctrl_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output stage_ctrl_t      ctrl_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int S = 1 << K;

    // Shift by S when selected; a pass-through stage keeps the incoming carry
    always_comb begin
        ctrl_o = ctrl_i;
        data_o = data_i;
        if (shift_i) begin
            case (ctrl_i.mode)
                MODE_LSL: begin
                    data_o       = data_i << S;
                    ctrl_o.carry = data_i[WIDTH-S];
                end
                MODE_LSR: begin
                    data_o       = data_i >> S;
                    ctrl_o.carry = data_i[S-1];
                end
                MODE_ASR: begin
                    data_o       = $signed(data_i) >>> S;
                    ctrl_o.carry = data_i[S-1];
                end
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
                MODE_ROL: begin
                    data_o       = {data_i[WIDTH-S-1:0], data_i[WIDTH-1:WIDTH-S]};
                    ctrl_o.carry = 1'b0;
                end
                MODE_ROR: begin
                    data_o       = {data_i[S-1:0], data_i[WIDTH-1:S]};
                    ctrl_o.carry = 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2-staged shift/rotate unit with valid/ready flow control
// Build option: PIPELINED_BARREL_SHIFTER_ROTATE_EN enables ROL/ROR; otherwise they act as LSL/LSR.
module pipelined_barrel_shifter
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    stage_ctrl_t      ctrl_in [SHW];
    logic [WIDTH-1:0] data_in [SHW];
    logic [SHW-1:0]   shift_in;
    stage_ctrl_t      ctrl_d  [SHW];
    logic [WIDTH-1:0] data_d  [SHW];
    logic [SHW-1:0]   amt_d   [SHW];
    stage_ctrl_t      ctrl_q  [SHW];
    logic [WIDTH-1:0] data_q  [SHW];
    logic [SHW-1:0]   amt_q   [SHW];
    stage_ctrl_t      head;
    logic             adv;

    // The whole pipeline moves as one: it advances unless the tail is stuck
    assign adv       = !ctrl_q[SHW-1].valid || out_ready;
    assign in_ready  = adv;
    assign head      = '{valid: in_valid && adv, carry: 1'b0, mode: effective_mode(in_mode)};
    assign out_valid = ctrl_q[SHW-1].valid;
    assign out_data  = data_q[SHW-1];
    assign out_carry = ctrl_q[SHW-1].carry;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign ctrl_in[k]  = head;
            assign data_in[k]  = in_data;
            assign shift_in[k] = in_amt[0];
            assign amt_d[k]    = in_amt;
        end else begin : g_tail
            assign ctrl_in[k]  = ctrl_q[k-1];
            assign data_in[k]  = data_q[k-1];
            assign shift_in[k] = amt_q[k-1][k];
            assign amt_d[k]    = amt_q[k-1];
        end
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .ctrl_i  (ctrl_in[k]),
            .data_i  (data_in[k]),
            .shift_i (shift_in[k]),
            .ctrl_o  (ctrl_d[k]),
            .data_o  (data_d[k])
        );
    end

    // Stage registers: reset flushes everything, otherwise load together on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SHW; i++) begin
                ctrl_q[i] <= '0;
                data_q[i] <= '0;
                amt_q[i]  <= '0;
            end
        end else if (adv) begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            amt_q  <= amt_d;
        end
    end

endmodule
